// File: rtl/instr_mem_loader_pkg.sv
// instr_mem_loader_pkg: processor constants and loader state encoding shared by the loader files.
package instr_mem_loader_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_BYTES = XLEN / 8;
  localparam int IMEM_DEPTH = 32;
  localparam int IMEM_ADDR_W = 5;
  localparam int NUM_WORDS_W = 6;
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} load_state_t;
endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// word_assembler: packs an accepted byte stream little-endian into 32-bit instruction words.
module word_assembler
  import instr_mem_loader_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic [7:0]      byte_data,
  output logic [XLEN-1:0] word,
  output logic            word_valid
);
  logic [$clog2(INSTR_BYTES)-1:0] idx;
  assign word_valid = en && idx == INSTR_BYTES - 1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      word <= '0;
    end else if (clr) begin
      idx  <= '0;
      word <= '0;
    end else if (en) begin
      word[{idx, 3'b000} +: 8] <= byte_data;
      idx                      <= idx + 1'b1;
    end
  end
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: loads a byte stream into instruction memory one word at a time.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NUM_WORDS_W-1:0] num_words,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic                   byte_ready,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [XLEN-1:0]        mem_wdata,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             checksum
);
  localparam int CW = ADDR_W + 1;
  load_state_t state, state_d;
  logic [CW-1:0] count, count_d;
  logic [ADDR_W-1:0] word_cnt;
  logic launch, accept, word_valid, last;
  // clamp so a request larger than the memory never wraps the word address
  assign count_d = CW'(int'(num_words) > DEPTH ? DEPTH : int'(num_words));
  assign launch = state == IDLE && start;
  assign accept = byte_valid && byte_ready;
  assign last = {1'b0, word_cnt} == count - CW'(1);
  assign byte_ready = state == COLLECT;
  assign mem_we = state == WRITE;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign mem_addr = word_cnt;
  word_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (launch),
    .en        (accept),
    .byte_data (byte_data),
    .word      (mem_wdata),
    .word_valid(word_valid)
  );
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = start ? (count_d == '0 ? DONE : COLLECT) : IDLE;
      COLLECT: state_d = word_valid ? WRITE : COLLECT;
      WRITE:   state_d = last ? DONE : COLLECT;
      DONE:    state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      word_cnt <= '0;
      checksum <= '0;
    end else if (launch) begin
      count    <= count_d;
      word_cnt <= '0;
      checksum <= '0;
    end else begin
      if (accept) checksum <= checksum + byte_data;
      if (state == WRITE && !last) word_cnt <= word_cnt + 1'b1;
    end
  end
endmodule
